jk_driver_checker: RTL and testbench

JK_DRIVER_CHECKER -- requirements
Module: jk_driver_checker

---
 rtl/jk_driver_checker.sv | 187 ++++++++++++++++++
 tb/tb_jk_driver_checker.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_driver_checker.sv
// jk_driver_checker
//
// Drives a JK flip-flop with a queued list of J/K stimulus entries and checks
// the returned Q/QB against an internal reference model.
//
// Flow: entries are pushed into a small FIFO while idle. A start command
// pulses the flip-flop's reset for one cycle (DRST). The FIFO then drains
// onto J/K, one entry per cycle (RUN). A final cycle (CHECK) applies J=K=0 so
// that the last entry's result can still be compared. A one-cycle done pulse
// (DONE) follows, then the block returns to IDLE.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   wr_en      push wr_jk into the FIFO (IDLE only)
//   wr_jk      stimulus entry, bit1 = j, bit0 = k
//   start      begin a run of all queued entries (IDLE only)
//   q, qb      outputs of the flip-flop under drive
//   j, k       registered J/K drive
//   dut_rst    registered reset drive, high for the DRST cycle
//   exp_q      reference model of Q
//   busy       high in every state except IDLE
//   done       one-cycle pulse at the end of a run
//   err        sticky mismatch flag, cleared by an accepted start
//   err_count  saturating mismatch count, cleared by an accepted start
//   full       FIFO holds DEPTH entries
//   ovf        sticky: a push was attempted while full
module jk_driver_checker #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [1:0]    wr_jk,
    input  logic          start,
    input  logic          q,
    input  logic          qb,
    output logic          j,
    output logic          k,
    output logic          dut_rst,
    output logic          exp_q,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] err_count,
    output logic          full,
    output logic          ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRST  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state;
    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          first_run;

    logic push;
    logic drop;
    logic go;
    logic go_run;
    logic pop;
    logic cmp_en;
    logic mismatch;

    always_comb begin
        push   = (state == S_IDLE) && wr_en && !full;
        drop   = (state == S_IDLE) && wr_en && full;
        go     = (state == S_IDLE) && start;
        // A push in the same cycle as start counts as a queued entry.
        go_run = go && ((count != '0) || push);
        // The first entry is popped while still in DRST so that it is already
        // on J/K in the first RUN cycle; each further RUN cycle pops one more.
        pop    = ((state == S_DRST) || (state == S_RUN)) && (count != '0);
        // The first RUN cycle only lets the flip-flop capture entry 0; Q still
        // reflects the reset, so nothing useful is compared there.
        cmp_en = ((state == S_RUN) && !first_run) || (state == S_CHECK);
        mismatch = cmp_en && ((q != exp_q) || (qb == q));
    end

    assign full = (count == FULL_LVL);
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // FIFO storage carries data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_jk;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            first_run <= 1'b0;
            j         <= 1'b0;
            k         <= 1'b0;
            dut_rst   <= 1'b0;
            exp_q     <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
            ovf       <= 1'b0;
        end else begin
            // FIFO bookkeeping: pushes only happen in IDLE and pops only in
            // DRST/RUN, so the two never coincide.
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                count  <= count + (AW + 1)'(1);
            end else if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                count  <= count - (AW + 1)'(1);
            end

            // Drive outputs: J/K carry the popped entry, otherwise idle at 0.
            if (pop) begin
                j <= mem[rd_ptr][1];
                k <= mem[rd_ptr][0];
            end else begin
                j <= 1'b0;
                k <= 1'b0;
            end
            dut_rst   <= go_run;
            first_run <= (state == S_DRST);

            // Reference model follows the J/K actually presented this cycle.
            if (dut_rst) begin
                exp_q <= 1'b0;
            end else begin
                case ({j, k})
                    2'b01:   exp_q <= 1'b0;
                    2'b10:   exp_q <= 1'b1;
                    2'b11:   exp_q <= ~exp_q;
                    default: exp_q <= exp_q;
                endcase
            end

            // Error tracking; an accepted start clears the previous result.
            if (go) begin
                err       <= 1'b0;
                err_count <= '0;
            end else if (mismatch) begin
                err <= 1'b1;
                if (err_count != {CW{1'b1}}) begin
                    err_count <= err_count + CW'(1);
                end
            end

            // Clear first so that a drop in the start cycle is still recorded.
            if (go_run) begin
                ovf <= 1'b0;
            end
            if (drop) begin
                ovf <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (go) begin
                        state <= go_run ? S_DRST : S_DONE;
                    end
                end
                S_DRST:  state <= S_RUN;
                S_RUN: begin
                    if (!pop) begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jk_driver_checker.sv
module tb_jk_driver_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       wr_en;
    logic [1:0] wr_jk;
    logic       start;
    logic       sat_sel;
    int         stuck;

    // Main instance (DEPTH 8)
    logic       j, k, dut_rst, exp_q, busy, done, err, full, ovf;
    logic [3:0] err_count;
    logic       q_ff, q_in, qb_in;

    // Saturation instance (DEPTH 16), fed Q = QB = 0 so every compare fails
    logic       s_j, s_k, s_dut_rst, s_exp_q, s_busy, s_done, s_err, s_full, s_ovf;
    logic [3:0] s_err_count;

    int n_chk  = 0;
    int n_fail = 0;

    jk_driver_checker #(.DEPTH(8), .CW(4)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en & ~sat_sel), .wr_jk(wr_jk),
        .start(start & ~sat_sel), .q(q_in), .qb(qb_in),
        .j(j), .k(k), .dut_rst(dut_rst), .exp_q(exp_q), .busy(busy), .done(done),
        .err(err), .err_count(err_count), .full(full), .ovf(ovf)
    );

    jk_driver_checker #(.DEPTH(16), .CW(4)) u_sat (
        .clk(clk), .rst(rst), .wr_en(wr_en & sat_sel), .wr_jk(wr_jk),
        .start(start & sat_sel), .q(1'b0), .qb(1'b0),
        .j(s_j), .k(s_k), .dut_rst(s_dut_rst), .exp_q(s_exp_q), .busy(s_busy),
        .done(s_done), .err(s_err), .err_count(s_err_count), .full(s_full), .ovf(s_ovf)
    );

    // Flip-flop under drive: a plain JK flop, or Q stuck at a constant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          q_ff <= 1'b0;
        else if (dut_rst) q_ff <= 1'b0;
        else begin
            case ({j, k})
                2'b01:   q_ff <= 1'b0;
                2'b10:   q_ff <= 1'b1;
                2'b11:   q_ff <= ~q_ff;
                default: q_ff <= q_ff;
            endcase
        end
    end
    assign q_in  = (stuck < 0) ? q_ff : stuck[0];
    assign qb_in = ~q_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: expected Q after each applied entry, mismatch count, and the
    // cycle (counted from the start cycle) on which done pulses.
    function automatic void model(input int n, input logic [31:0] ents, input int stk,
                                  output logic [15:0] expq, output int cnt, output int lat);
        int   napp;
        logic e;
        napp = (n > 8) ? 8 : n;
        e    = 1'b0;
        expq = '0;
        cnt  = 0;
        for (int i = 0; i < napp; i++) begin
            case (ents[2*i +: 2])
                2'b01:   e = 1'b0;
                2'b10:   e = 1'b1;
                2'b11:   e = ~e;
                default: e = e;
            endcase
            expq[i] = e;
            if (stk >= 0 && e != stk[0]) cnt++;
        end
        if (cnt > 15) cnt = 15;
        lat = (napp == 0) ? 1 : napp + 3;
    endfunction

    // Push n entries, start, follow the run cycle by cycle and check it.
    task automatic do_run(input string name, input int n, input logic [31:0] ents, input int stk,
                          input logic [15:0] expq, input int ecnt, input int lat);
        int         napp, done_at, rst_hi, busy_n;
        logic [1:0] jk_s [64];
        logic       eq_s [64];
        napp  = (n > 8) ? 8 : n;
        stuck = stk;
        for (int i = 0; i < n; i++) begin
            wr_en = 1'b1;
            wr_jk = ents[2*i +: 2];
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk({name, ".full"}, 32'(full), 32'(n >= 8));
        chk({name, ".ovf"}, 32'(ovf), 32'(n > 8));
        start   = 1'b1;
        done_at = -1;
        rst_hi  = 0;
        busy_n  = 0;
        for (int c = 1; c <= 30 && done_at < 0; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            jk_s[c] = {j, k};
            eq_s[c] = exp_q;
            rst_hi += int'(dut_rst);
            busy_n += int'(busy);
            if (dut_rst) chk({name, ".dut_rst_cycle"}, 32'(c), 32'd1);
            if (done) done_at = c;
        end
        chk({name, ".done_latency"}, 32'(done_at), 32'(lat));
        if (done_at > 0) begin
            chk({name, ".dut_rst_cycles"}, 32'(rst_hi), 32'(napp > 0));
            chk({name, ".busy_cycles"}, 32'(busy_n), 32'(lat));
            chk({name, ".err"}, 32'(err), 32'(ecnt > 0));
            chk({name, ".err_count"}, 32'(err_count), 32'(ecnt));
            for (int i = 0; i < napp; i++) begin
                chk({name, ".jk"}, 32'(jk_s[2+i]), 32'(ents[2*i +: 2]));
                chk({name, ".exp_q"}, 32'(eq_s[3+i]), 32'(expq[i]));
            end
            if (napp > 0) chk({name, ".jk_check"}, 32'(jk_s[napp+2]), 32'd0);
            else          chk({name, ".jk_idle"}, 32'(jk_s[1]), 32'd0);
        end
        @(negedge clk);
        chk({name, ".busy_after"}, 32'(busy), 32'd0);
        chk({name, ".done_after"}, 32'(done), 32'd0);
    endtask

    typedef struct {
        string       name;
        int          n;
        logic [31:0] ents;
        int          stk;
        logic [15:0] expq;
        int          cnt;
        int          lat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [15:0] m_expq;
        logic [31:0] r_ents;
        int          m_cnt, m_lat, r_n, r_stk, done_at, done_n;

        vecs[0] = '{"basic",       4, 32'hC6,    -1, 16'h0009, 0, 7};
        vecs[1] = '{"stuck0",      4, 32'hFF,     0, 16'h0005, 2, 7};
        vecs[2] = '{"overflow",    9, 32'h3FFFF, -1, 16'h0055, 0, 11};
        vecs[3] = '{"empty",       0, 32'h0,     -1, 16'h0000, 0, 1};
        vecs[4] = '{"one_miss",    1, 32'h1,      1, 16'h0000, 1, 4};
        vecs[5] = '{"stuck_match", 3, 32'h0A,     1, 16'h0007, 0, 6};

        rst = 1'b1; wr_en = 1'b0; wr_jk = 2'b00; start = 1'b0; sat_sel = 1'b0; stuck = -1;
        repeat (2) @(negedge clk);
        chk("reset.jk_rst_expq", 32'({j, k, dut_rst, exp_q}), 32'd0);
        chk("reset.busy_done", 32'({busy, done}), 32'd0);
        chk("reset.err", 32'({err, err_count}), 32'd0);
        chk("reset.full_ovf", 32'({full, ovf}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            do_run(vecs[v].name, vecs[v].n, vecs[v].ents, vecs[v].stk,
                   vecs[v].expq, vecs[v].cnt, vecs[v].lat);
        end

        // Pushes and start during a run are ignored.
        stuck = -1;
        wr_jk = 2'b10; wr_en = 1'b1; @(negedge clk);
        wr_jk = 2'b11;               @(negedge clk);
        wr_en = 1'b0;
        start = 1'b1;
        done_at = -1;
        for (int c = 1; c <= 12 && done_at < 0; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 2) begin wr_en = 1'b1; start = 1'b1; end
            if (c == 4) begin wr_en = 1'b0; start = 1'b0; end
            if (done) done_at = c;
        end
        chk("busy_ignore.done_latency", 32'(done_at), 32'd5);
        chk("busy_ignore.err", 32'(err), 32'd0);
        chk("busy_ignore.ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        do_run("busy_ignore.drained", 0, 32'h0, -1, 16'h0, 0, 1);

        // Reset in the third RUN cycle aborts the run.
        stuck = 0;
        for (int i = 0; i < 4; i++) begin wr_en = 1'b1; wr_jk = 2'b11; @(negedge clk); end
        wr_en = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        chk("abort.err_before", 32'(err), 32'd1);
        chk("abort.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort.jk_rst_expq", 32'({j, k, dut_rst, exp_q}), 32'd0);
        chk("abort.busy_done", 32'({busy, done}), 32'd0);
        chk("abort.err", 32'({err, err_count}), 32'd0);
        chk("abort.full_ovf", 32'({full, ovf}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            done_n += int'(done);
        end
        chk("abort.no_done", 32'(done_n), 32'd0);
        do_run("abort.empty_start", 0, 32'h0, -1, 16'h0, 0, 1);

        // Saturation: 16 mismatching compares on a 4-bit counter.
        sat_sel = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_jk = 2'($urandom); @(negedge clk);
        end
        wr_en = 1'b0;
        chk("sat.full", 32'(s_full), 32'd1);
        start = 1'b1;
        done_at = -1;
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (s_done) done_at = c;
        end
        chk("sat.done_latency", 32'(done_at), 32'd19);
        chk("sat.err", 32'(s_err), 32'd1);
        chk("sat.err_count", 32'(s_err_count), 32'd15);
        @(negedge clk);
        sat_sel = 1'b0;

        // Randomized runs against the reference model.
        for (int it = 0; it < 30; it++) begin
            r_n    = int'($urandom_range(0, 10));
            r_ents = $urandom;
            r_stk  = int'($urandom_range(0, 2)) - 1;
            model(r_n, r_ents, r_stk, m_expq, m_cnt, m_lat);
            do_run("rand", r_n, r_ents, r_stk, m_expq, m_cnt, m_lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
